fp_cvt_d_int_pipe: RTL

Pipelined integer-to-double converter for the D-extension ALU, covering FCVT.D.L, FCVT.D.LU, FCVT.D.W and FCVT.D.WU. Source width is parametrised, signed and unsigned sources are selected per operation, and all five RISC-V static rounding modes are supported with an inexact flag. A valid/ready handshake on both sides lets the block sit between the FP issue stage and the FP writeback arbiter, accepting one conversion per cycle with back-pressure.

---
 rtl/fp_cvt_pkg.sv | 40 ++++
 rtl/fp_lzc.sv | 49 ++++
 rtl/fp_cvt_d_int_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fp_cvt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_cvt_pkg
//  Description : Shared rounding-mode encodings, double-format widths and the
//                round-increment decision for the FP conversion units.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_cvt_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int DBL_EXP_W = 11;
    localparam int DBL_MAN_W = 52;
    localparam int DBL_BIAS  = 1023;

    // Reserved encodings fall through to round-to-nearest-even.
    function automatic logic round_inc(
        input logic [2:0] rm,
        input logic       sign,
        input logic       lsb,
        input logic       guard,
        input logic       sticky
    );
        logic inc;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
        return inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Combinational leading-zero counter built as a binary
//                priority tree, with an all-zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_lzc #(
    parameter int W = 64
) (
    input  logic [W-1:0]         i_data,
    output logic [$clog2(W)-1:0] o_cnt,
    output logic                 o_zero
);

    localparam int c_cw = $clog2(W);
    localparam int c_p  = 1 << c_cw;

    logic [c_p-1:0]  w_pad;
    logic            w_vld [1:2*c_p-1];
    logic [c_cw-1:0] w_cnt [1:2*c_p-1];

    // Padding sits below the LSB so it never shifts the count of a non-zero input.
    if (c_p > W) begin : g_pad
        assign w_pad = {i_data, {(c_p-W){1'b0}}};
    end else begin : g_nopad
        assign w_pad = i_data;
    end

    // Heap-indexed tree: node k has children 2k (upper half) and 2k+1 (lower half).
    always_comb begin
        for (int k = 0; k < c_p; k++) begin
            w_vld[c_p+k] = w_pad[c_p-1-k];
            w_cnt[c_p+k] = '0;
        end
        for (int d = c_cw - 1; d >= 0; d--) begin
            for (int k = (1 << d); k < (2 << d); k++) begin
                w_vld[k] = w_vld[2*k] | w_vld[2*k+1];
                w_cnt[k] = w_vld[2*k] ? w_cnt[2*k]
                                      : (w_cnt[2*k+1] | c_cw'(1 << (c_cw - 1 - d)));
            end
        end
    end

    assign o_cnt  = w_cnt[1];
    assign o_zero = ~w_vld[1];

endmodule
`default_nettype wire

// File: rtl/fp_cvt_d_int_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_cvt_d_int_pipe
//  Description : Three-stage integer-to-double converter (FCVT.D.{L,LU,W,WU})
//                with valid/ready flow control on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_cvt_d_int_pipe
    import fp_cvt_pkg::*;
#(
    parameter int INT_W = 64,
    parameter int EXP_W = DBL_EXP_W,
    parameter int MAN_W = DBL_MAN_W,
    parameter int BIAS  = DBL_BIAS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INT_W-1:0]       in_int,
    input  logic                   in_signed,
    input  logic [2:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_d,
    output logic                   out_nx
);

    localparam int               c_lzc_w   = $clog2(INT_W);
    localparam logic [EXP_W-1:0] c_exp_top = EXP_W'(BIAS + INT_W - 1);

    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic [INT_W-2:0]     r_s1_mag;
    logic [c_lzc_w-1:0]   r_s1_lzc;
    logic                 r_s1_zero;
    logic [2:0]           r_s1_rm;

    logic                 r_s2_valid;
    logic                 r_s2_sign;
    logic [EXP_W-1:0]     r_s2_exp;
    logic [MAN_W-1:0]     r_s2_mant;
    logic                 r_s2_guard;
    logic                 r_s2_sticky;
    logic [2:0]           r_s2_rm;

    logic                 r_s3_valid;

    // ---------------------------------------------------------------- flow
    logic w_s1_adv, w_s2_adv, w_s3_adv;
    logic w_s1_en, w_s2_en, w_s3_en;

    assign w_s3_adv  = r_s3_valid & out_ready;
    assign w_s3_en   = ~r_s3_valid | w_s3_adv;
    assign w_s2_adv  = r_s2_valid & w_s3_en;
    assign w_s2_en   = ~r_s2_valid | w_s2_adv;
    assign w_s1_adv  = r_s1_valid & w_s2_en;
    assign w_s1_en   = ~r_s1_valid | w_s1_adv;
    assign in_ready  = rst_n & w_s1_en;
    assign out_valid = r_s3_valid;

    // ---------------------------------------------------------------- S1
    logic               w_sign;
    logic [INT_W-1:0]   w_mag;
    logic [c_lzc_w-1:0] w_lzc;
    logic               w_zero;

    assign w_sign = in_signed & in_int[INT_W-1];
    assign w_mag  = w_sign ? (~in_int + INT_W'(1)) : in_int;

    fp_lzc #(
        .W (INT_W)
    ) u_lzc (
        .i_data (w_mag),
        .o_cnt  (w_lzc),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
        end
    end

    // The leading one is implicit after normalisation, so only the bits below the MSB are kept.
    always_ff @(posedge clk) begin
        if (w_s1_en & in_valid) begin
            r_s1_sign <= w_sign;
            r_s1_mag  <= w_mag[INT_W-2:0];
            r_s1_lzc  <= w_lzc;
            r_s1_zero <= w_zero;
            r_s1_rm   <= in_rm;
        end
    end

    // ---------------------------------------------------------------- S2
    logic [INT_W-2:0] w_norm;
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_mant;
    logic             w_guard;
    logic             w_sticky;

    assign w_norm = r_s1_mag << r_s1_lzc;
    assign w_exp  = r_s1_zero ? '0 : (c_exp_top - EXP_W'(r_s1_lzc));

    if (INT_W - 1 > MAN_W + 1) begin : g_guard_sticky
        assign w_mant   = w_norm[INT_W-2 -: MAN_W];
        assign w_guard  = w_norm[INT_W-2-MAN_W];
        assign w_sticky = |w_norm[INT_W-3-MAN_W:0];
    end else if (INT_W - 1 == MAN_W + 1) begin : g_guard_only
        assign w_mant   = w_norm[INT_W-2 -: MAN_W];
        assign w_guard  = w_norm[0];
        assign w_sticky = 1'b0;
    end else if (INT_W - 1 == MAN_W) begin : g_exact
        assign w_mant   = w_norm;
        assign w_guard  = 1'b0;
        assign w_sticky = 1'b0;
    end else begin : g_zero_pad
        assign w_mant   = {w_norm, {(MAN_W-INT_W+1){1'b0}}};
        assign w_guard  = 1'b0;
        assign w_sticky = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s2_en & r_s1_valid) begin
            r_s2_sign   <= r_s1_sign;
            r_s2_exp    <= w_exp;
            r_s2_mant   <= w_mant;
            r_s2_guard  <= w_guard;
            r_s2_sticky <= w_sticky;
            r_s2_rm     <= r_s1_rm;
        end
    end

    // ---------------------------------------------------------------- S3
    logic             w_inc;
    logic [MAN_W:0]   w_mant_sum;
    logic [EXP_W-1:0] w_exp_rnd;

    assign w_inc      = round_inc(r_s2_rm, r_s2_sign, r_s2_mant[0], r_s2_guard, r_s2_sticky);
    assign w_mant_sum = {1'b0, r_s2_mant} + (MAN_W+1)'(w_inc);
    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    assign w_exp_rnd  = r_s2_exp + EXP_W'(w_mant_sum[MAN_W]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            out_d      <= '0;
            out_nx     <= 1'b0;
        end else begin
            if (w_s3_en) begin
                r_s3_valid <= r_s2_valid;
            end
            if (w_s3_en & r_s2_valid) begin
                out_d  <= {r_s2_sign, w_exp_rnd, w_mant_sum[MAN_W-1:0]};
                out_nx <= r_s2_guard | r_s2_sticky;
            end
        end
    end

endmodule
`default_nettype wire
